// File: rtl/alu_pkg.sv
// Shared definitions for the round-robin ALU scheduler: opcodes, FSM states
// and the fixed results used on divide/modulo by zero.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_MUL  = 4'h2;
  localparam logic [3:0] OP_DIV  = 4'h3;
  localparam logic [3:0] OP_NOT  = 4'h4;
  localparam logic [3:0] OP_AND  = 4'h5;
  localparam logic [3:0] OP_OR   = 4'h6;
  localparam logic [3:0] OP_NAND = 4'h7;
  localparam logic [3:0] OP_NOR  = 4'h8;
  localparam logic [3:0] OP_XOR  = 4'h9;
  localparam logic [3:0] OP_XNOR = 4'hA;
  localparam logic [3:0] OP_MOD  = 4'hB;
  localparam logic [3:0] OP_INC  = 4'hC;
  localparam logic [3:0] OP_DEC  = 4'hD;
  localparam logic [3:0] OP_LNOT = 4'hE;
  localparam logic [3:0] OP_POW  = 4'hF;

  // Division by zero saturates to all ones; modulo by zero passes a through.
  localparam logic [3:0] DZ_DIV_RESULT = 4'hF;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_core.sv
// Combinational 4-bit ALU; every result wraps modulo 16, output forced to zero
// when not enabled.
module alu_core
  import alu_pkg::*;
(
  input  logic       en,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [3:0] sel,
  output logic [3:0] result,
  output logic       dz
);

  logic [7:0] prod;

  // Repeated multiply keeps only the low nibble, so a**b wraps like every other op.
  function automatic logic [3:0] pow_wrap(input logic [3:0] base, input logic [3:0] ex);
    logic [3:0] r;
    logic [7:0] t;
    r = 4'd1;
    for (int i = 0; i < 15; i++) begin
      if (i < int'(ex)) begin
        t = r * base;
        r = t[3:0];
      end
    end
    return r;
  endfunction

  assign prod = a * b;

  always_comb begin
    result = '0;
    dz     = 1'b0;
    if (en) begin
      case (sel)
        OP_ADD:  result = a + b;
        OP_SUB:  result = a - b;
        OP_MUL:  result = prod[3:0];
        OP_DIV:  begin
          if (b == 4'd0) begin
            result = DZ_DIV_RESULT;
            dz     = 1'b1;
          end else begin
            result = a / b;
          end
        end
        OP_NOT:  result = ~a;
        OP_AND:  result = a & b;
        OP_OR:   result = a | b;
        OP_NAND: result = ~(a & b);
        OP_NOR:  result = ~(a | b);
        OP_XOR:  result = a ^ b;
        OP_XNOR: result = ~(a ^ b);
        OP_MOD:  begin
          if (b == 4'd0) begin
            result = a;
            dz     = 1'b1;
          end else begin
            result = a % b;
          end
        end
        OP_INC:  result = a + 4'd1;
        OP_DEC:  result = a - 4'd1;
        OP_LNOT: result = (a == 4'd0) ? 4'd1 : 4'd0;
        OP_POW:  result = pow_wrap(a, b);
        default: result = '0;
      endcase
    end
  end

endmodule

// File: rtl/alu_sched.sv
// Round-robin scheduler sharing one ALU among N_REQ requesters:
// IDLE grants and captures, EXEC evaluates, RESP holds the result until taken.
module alu_sched
  import alu_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int TAG_W = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [4*N_REQ-1:0] req_a,
  input  logic [4*N_REQ-1:0] req_b,
  input  logic [4*N_REQ-1:0] req_sel,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [3:0]         rsp_result,
  output logic [TAG_W-1:0]   rsp_tag,
  output logic               rsp_dz,
  output logic               busy
);

  state_t           state;
  logic [TAG_W-1:0] rr_ptr;
  logic [TAG_W-1:0] gidx;
  logic [TAG_W-1:0] arb_idx;
  logic             found;
  logic [3:0]       win_a, win_b, win_sel;
  logic [3:0]       op_a_p0, op_b_p0, op_sel_p0;
  logic [TAG_W-1:0] op_tag_p0;
  logic [3:0]       core_result;
  logic             core_dz;

  // First valid requester at or after rr_ptr, wrapping around.
  always_comb begin
    found   = 1'b0;
    gidx    = '0;
    arb_idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      arb_idx = TAG_W'((int'(rr_ptr) + k) % N_REQ);
      if (!found && req_valid[arb_idx]) begin
        found = 1'b1;
        gidx  = arb_idx;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (rst_n && (state == S_IDLE) && found) req_ready[gidx] = 1'b1;
  end

  assign win_a   = req_a[{gidx, 2'b00} +: 4];
  assign win_b   = req_b[{gidx, 2'b00} +: 4];
  assign win_sel = req_sel[{gidx, 2'b00} +: 4];
  assign busy    = (state != S_IDLE);

  alu_core u_core (
    .en     (state == S_EXEC),
    .a      (op_a_p0),
    .b      (op_b_p0),
    .sel    (op_sel_p0),
    .result (core_result),
    .dz     (core_dz)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      rr_ptr     <= '0;
      op_a_p0    <= '0;
      op_b_p0    <= '0;
      op_sel_p0  <= '0;
      op_tag_p0  <= '0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_tag    <= '0;
      rsp_dz     <= 1'b0;
    end else begin
      case (state)
        // p0: operand capture on transfer
        S_IDLE: begin
          if (found) begin
            op_a_p0   <= win_a;
            op_b_p0   <= win_b;
            op_sel_p0 <= win_sel;
            op_tag_p0 <= gidx;
            rr_ptr    <= (gidx == TAG_W'(N_REQ - 1)) ? '0 : gidx + TAG_W'(1);
            state     <= S_EXEC;
          end
        end
        // p1: ALU result registered into the response
        S_EXEC: begin
          rsp_result <= core_result;
          rsp_dz     <= core_dz;
          rsp_tag    <= op_tag_p0;
          rsp_valid  <= 1'b1;
          state      <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sched.sv
// Bench for alu_sched: directed literal cases plus randomized traffic checked
// every cycle against a transaction-level model of the scheduler.
module tb_alu_sched;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid, req_ready;
  logic [4*N-1:0] req_a, req_b, req_sel;
  logic           rsp_valid, rsp_ready, rsp_dz, busy;
  logic [3:0]     rsp_result;
  logic [1:0]     rsp_tag;

  int vectors = 0, miscompares = 0, cyc = 0;

  alu_sched #(.N_REQ(N), .TAG_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sel(req_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_tag(rsp_tag), .rsp_dz(rsp_dz), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference ALU written straight from the opcode table.
  function automatic void alu_ref(input int a, input int b, input int s,
                                  output int r, output int dz);
    dz = 0;
    case (s)
      0:  r = (a + b) % 16;
      1:  r = (a - b + 16) % 16;
      2:  r = (a * b) % 16;
      3:  if (b == 0) begin r = 15; dz = 1; end else r = a / b;
      4:  r = 15 - a;
      5:  r = a & b;
      6:  r = a | b;
      7:  r = 15 - (a & b);
      8:  r = 15 - (a | b);
      9:  r = a ^ b;
      10: r = 15 - (a ^ b);
      11: if (b == 0) begin r = a; dz = 1; end else r = a % b;
      12: r = (a + 1) % 16;
      13: r = (a + 15) % 16;
      14: r = (a == 0) ? 1 : 0;
      default: begin
        r = 1;
        for (int i = 0; i < b; i++) r = (r * a) % 16;
      end
    endcase
  endfunction

  // Transaction model: phase 0 waiting for a request, 1 computing, 2 offering a result.
  int m_phase = 0, m_ptr = 0, m_w, e_res, e_tag, e_dz, exp_ready;
  logic [N-1:0] last_ready = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rsp_result", rsp_result, 0);
      chk("rst_rsp_tag", rsp_tag, 0);
      chk("rst_rsp_dz", rsp_dz, 0);
      m_phase = 0;
      m_ptr = 0;
      last_ready = '0;
    end else begin
      m_w = -1;
      for (int k = 0; k < N; k++)
        if (m_w < 0 && req_valid[(m_ptr + k) % N]) m_w = (m_ptr + k) % N;
      exp_ready = (m_phase == 0 && m_w >= 0) ? (1 << m_w) : 0;
      chk("req_ready", req_ready, exp_ready);
      chk("busy", busy, (m_phase != 0) ? 1 : 0);
      chk("rsp_valid", rsp_valid, (m_phase == 2) ? 1 : 0);
      if (m_phase == 2) begin
        chk("rsp_result", rsp_result, e_res);
        chk("rsp_tag", rsp_tag, e_tag);
        chk("rsp_dz", rsp_dz, e_dz);
      end
      last_ready = req_ready;
      case (m_phase)
        0: if (m_w >= 0) begin
             alu_ref(req_a[4*m_w +: 4], req_b[4*m_w +: 4], req_sel[4*m_w +: 4], e_res, e_dz);
             e_tag = m_w;
             m_ptr = (m_w + 1) % N;
             m_phase = 1;
           end
        1: m_phase = 2;
        default: if (rsp_ready) m_phase = 0;
      endcase
    end
  end

  task automatic set_req(input int i, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] s);
    req_a[4*i +: 4] = a;
    req_b[4*i +: 4] = b;
    req_sel[4*i +: 4] = s;
  endtask

  // Issues one operation, checks grant, latency and the literal result.
  task automatic issue(input int i, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] s, input int er, input int ed, input string nm);
    int t, n;
    set_req(i, a, b, s);
    req_valid[i] = 1'b1;
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      if (req_ready[i]) break;
      n++;
    end
    chk({nm, "_grant"}, req_ready[i], 1);
    t = cyc;
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
    n = 0;
    while (n < 10) begin
      @(negedge clk);
      if (rsp_valid) break;
      n++;
    end
    chk({nm, "_latency"}, cyc - t, 2);
    chk({nm, "_result"}, rsp_result, er);
    chk({nm, "_tag"}, rsp_tag, i);
    chk({nm, "_dz"}, rsp_dz, ed);
    @(posedge clk); #1;
  endtask

  int order[5];
  int ng, n;

  initial begin
    rst_n = 1'b0;
    req_valid = '1;
    req_a = '0; req_b = '0; req_sel = '0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 req_valid = '0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    issue(1, 4'h7, 4'h5, 4'h0, 'hC, 0, "add");
    issue(0, 4'h9, 4'h0, 4'h3, 'hF, 1, "div0");
    issue(3, 4'h9, 4'h0, 4'hB, 9, 1, "mod0");
    issue(2, 4'hF, 4'h2, 4'h2, 'hE, 0, "mul_wrap");
    issue(1, 4'h0, 4'h1, 4'hD, 'hF, 0, "dec_wrap");
    issue(0, 4'h3, 4'h3, 4'hF, 'hB, 0, "pow_wrap");
    issue(2, 4'h0, 4'h0, 4'hF, 1, 0, "pow_zero");

    // Backpressure: rsp_ready low for five cycles in RESP, another requester waiting.
    rsp_ready = 1'b0;
    issue(2, 4'h6, 4'h3, 4'h1, 3, 0, "bp");
    req_valid[0] = 1'b1;
    for (int k = 1; k < 5; k++) begin
      @(negedge clk);
      chk("bp_hold_valid", rsp_valid, 1);
      chk("bp_hold_result", rsp_result, 3);
      chk("bp_hold_tag", rsp_tag, 2);
      chk("bp_hold_ready", req_ready, 0);
      chk("bp_hold_busy", busy, 1);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    req_valid[0] = 1'b0;
    @(negedge clk);
    chk("bp_accept_valid", rsp_valid, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_after_valid", rsp_valid, 0);
    @(posedge clk); #1;

    // Reset while EXEC: the operation is dropped and the pointer restarts at 0.
    set_req(2, 4'h5, 4'h5, 4'h0);
    req_valid[2] = 1'b1;
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      if (req_ready[2]) break;
      n++;
    end
    chk("rst_exec_grant", req_ready[2], 1);
    @(posedge clk); #1;
    req_valid[2] = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("rst_exec_no_rsp", rsp_valid, 0);
    end
    @(posedge clk); #1;

    // All requesters valid continuously from rr_ptr 0.
    for (int i = 0; i < N; i++) set_req(i, 4'(i), 4'(i + 1), 4'h2);
    req_valid = '1;
    ng = 0;
    n = 0;
    while (ng < 5 && n < 60) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) if (req_ready[i]) begin order[ng] = i; ng++; end
      n++;
    end
    chk("rr_grants", ng, 5);
    for (int k = 0; k < 5; k++) chk($sformatf("rr_order%0d", k), order[k], k % N);
    @(posedge clk); #1;
    req_valid = '0;
    repeat (4) @(posedge clk);
    #1;

    // Randomized traffic, checked by the model.
    for (int c = 0; c < 500; c++) begin
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && !last_ready[i]) begin
          if ($urandom_range(7) == 0) req_valid[i] = 1'b0;
        end else begin
          req_valid[i] = 1'b0;
          if ($urandom_range(1) == 1) begin
            set_req(i, 4'($urandom_range(15)),
                    ($urandom_range(3) == 0) ? 4'h0 : 4'($urandom_range(15)),
                    4'($urandom_range(15)));
            req_valid[i] = 1'b1;
          end
        end
      end
      rsp_ready = 1'($urandom_range(1));
      @(posedge clk); #1;
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
